cache_c1_port: RTL and testbench
================================

Name: cache_c1_port

Overview:
- CPU-facing slave port of the L1 cache. Sits directly downstream of the CPU on bus 1 (C1/D1/A1).
- Decodes C1 commands and assembles the two-tick address/data transfer into one request for the cache core.
- Waits for the core, then drives C1_RESPONSE and read data back to the CPU before returning bus ownership.

Parameters:
- TAG_BITS, 10, tag width carried on A1 in tick 1
- SET_BITS, 5, set-index width carried on A1 in tick 1 (TAG_BITS+SET_BITS = A1 width = 15)
- OFFSET_BITS, 4, byte offset carried on A1[OFFSET_BITS-1:0] in tick 2

Ports:
- clk  input  1  clock; everything updates on the posedge
- reset  input  1  synchronous, active-high
- C1  inout  3  command bus: CPU drives it in IDLE/ADDR2, this port drives it otherwise
- D1  inout  16  data bus, same ownership rule as C1 (port drives only on read responses)
- A1  input  15  address bus, always driven by the CPU
- req_valid  output  1  request to the core
- req_ready  input  1  core accepts the request
- req_cmd  output  3  latched command code (1..7)
- req_tag  output  TAG_BITS  latched A1[14:5]
- req_set  output  SET_BITS  latched A1[4:0]
- req_offset  output  OFFSET_BITS  latched tick-2 A1[3:0]
- req_wdata  output  32  write data {tick2 D1, tick1 D1}
- resp_valid  input  1  core completion
- resp_rdata  input  32  read data, right-aligned

Behaviour:
- Command codes: 0 NOP, 1 READ8, 2 READ16, 3 READ32, 4 INVALIDATE_LINE, 5 WRITE8, 6 WRITE16, 7 WRITE32. In the response phase, code 7 means C1_RESPONSE.
- Reset: state=IDLE, req_valid=0, all req_* payload=0, C1 and D1 released (high-Z).
- Reset asserted in any state aborts the transaction the same edge and drops req_valid. No response is sent.
- IDLE: C1/D1 high-Z. On an edge with C1!=0, latch cmd, tag=A1[14:5], set=A1[4:0], wdata[15:0]=D1, then go to ADDR2. C1==0 or X/Z stays in IDLE.
- ADDR2: C1/D1 high-Z. Latch offset=A1[3:0]. For WRITE32 also latch wdata[31:16]=D1; all other commands clear wdata[31:16] to 0. Go to ISSUE.
- ISSUE: port drives C1=NOP and req_valid=1 with the payload held stable.
  - req_ready=0: stay in ISSUE.
  - req_ready=1 with resp_valid=0: go to WAIT.
  - req_ready=1 with resp_valid=1 in the same cycle: latch rdata and go straight to RESP1.
- WAIT: req_valid=0, C1=NOP. On resp_valid, latch resp_rdata and go to RESP1. resp_valid is ignored outside ISSUE and WAIT.
- RESP1: C1=RESPONSE (7).
  - READ8: D1={8'h00, rdata[7:0]}.
  - READ16: D1=rdata[15:0].
  - READ32: D1=rdata[15:0], then go to RESP2.
  - Writes and invalidate: D1 high-Z.
  - All non-READ32 commands return to IDLE.
- RESP2 (READ32 only): C1=RESPONSE, D1=rdata[31:16], then go to IDLE.
- Bus release: the port tri-states C1/D1 in the cycle after its last response tick. A new CPU command may be sampled on the first IDLE edge.
- Latency: command sampled at edge E0 → req_valid high after E1 → earliest C1=RESPONSE after E2 (3 edges).
- Commands presented while the port is not in IDLE are not sampled; the port owns C1 then.

Optional Feature:
- Macro: C1_ALIGN_CHECK_EN.
- Defined: in ADDR2 a misaligned access is detected: READ16/WRITE16 with odd offset, or READ32/WRITE32 with offset[1:0]!=0. It is never issued (req_valid stays 0). The port goes ADDR2→RESP1 as a single RESPONSE tick, with D1=16'h0000 for reads and high-Z for writes; READ32 has no RESP2.
- Undefined: offsets are passed through unchecked; the core handles alignment.

Test Plan:
- Reset in WAIT during READ32 → next cycle IDLE, req_valid=0, C1/D1 high-Z; CPU then issues READ8 at tag=0x155, set=0x0A, offset=0x3 and core returns 0x000000AB → one RESPONSE tick with D1=0x00AB.
- READ32 at offset 0x4, core resp_rdata=0xDEADBEEF after 5 WAIT cycles → two RESPONSE ticks, D1=0xBEEF then 0xDEAD, then high-Z.
- WRITE32 with D1 tick1=0x1234, tick2=0x5678, req_ready held 0 for 3 cycles → req_valid high for 4 cycles, req_wdata=0x56781234 stable throughout, req_cmd=7; then resp_valid → one RESPONSE tick, D1 high-Z.
- INVALIDATE_LINE with req_ready and resp_valid asserted in the same ISSUE cycle → RESPONSE exactly one cycle later, no WAIT cycle.
- Back-to-back WRITE8 then READ16 with the CPU re-driving C1 in the first IDLE cycle → both serviced; the second command is sampled on the edge right after release.
- With C1_ALIGN_CHECK_EN defined, READ32 at offset 0x2 → req_valid never rises, a single RESPONSE tick with D1=0x0000; without the macro the request is issued with req_offset=0x2.

Source files
------------

// File: rtl/cache_c1_port_if.sv
// Request/response handshake between the C1 slave port and the L1 cache core.
// master = CPU-facing port (issues requests), slave = cache core (accepts, completes).
// Purely combinational wiring; no storage or latency of its own.
interface cache_c1_port_if #(
  parameter int TAG_BITS    = 10,
  parameter int SET_BITS    = 5,
  parameter int OFFSET_BITS = 4
);
  logic                   req_valid;
  logic                   req_ready;
  logic [2:0]             req_cmd;
  logic [TAG_BITS-1:0]    req_tag;
  logic [SET_BITS-1:0]    req_set;
  logic [OFFSET_BITS-1:0] req_offset;
  logic [31:0]            req_wdata;
  logic                   resp_valid;
  logic [31:0]            resp_rdata;

  modport master (
    output req_valid, req_cmd, req_tag, req_set, req_offset, req_wdata,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_cmd, req_tag, req_set, req_offset, req_wdata,
    output req_ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/cache_c1_port.sv
// CPU-facing C1/D1/A1 slave port: merges the two-tick address/data transfer into one core request.
// Latency: command at edge E0 -> req_valid after E1 -> earliest C1=RESPONSE after E2.
// Holds req_valid and payload while req_ready is low; optional C1_ALIGN_CHECK_EN rejects misaligned accesses.
module cache_c1_port #(
  parameter int TAG_BITS    = 10,
  parameter int SET_BITS    = 5,
  parameter int OFFSET_BITS = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  inout  wire  [2:0]                   C1,
  inout  wire  [15:0]                  D1,
  input  logic [TAG_BITS+SET_BITS-1:0] A1,
  cache_c1_port_if.master              core
);

  localparam logic [2:0] CMD_NOP    = 3'd0;
  localparam logic [2:0] CMD_READ8  = 3'd1;
  localparam logic [2:0] CMD_READ16 = 3'd2;
  localparam logic [2:0] CMD_READ32 = 3'd3;
  localparam logic [2:0] CMD_WR16   = 3'd6;
  localparam logic [2:0] CMD_WR32   = 3'd7;
  localparam logic [2:0] CMD_RESP   = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR2, S_ISSUE, S_WAIT, S_RESP1, S_RESP2
  } state_e;

  state_e                 state_q, state_d;
  logic [2:0]             cmd_q;
  logic [TAG_BITS-1:0]    tag_q;
  logic [SET_BITS-1:0]    set_q;
  logic [OFFSET_BITS-1:0] off_q;
  logic [31:0]            wdata_q;
  logic [31:0]            rdata_q;
  logic                   mis_q;

  logic                   cmd_vld;
  logic                   is_read;
  logic                   misaligned;
  logic                   req_vld;
  logic                   c1_oe, d1_oe;
  logic [2:0]             c1_out;
  logic [15:0]            d1_out;

  // Only a fully known, non-NOP code on C1 starts a transaction.
  assign cmd_vld = (C1 != CMD_NOP) && !$isunknown(C1);
  assign is_read = (cmd_q == CMD_READ8) || (cmd_q == CMD_READ16) || (cmd_q == CMD_READ32);

`ifdef C1_ALIGN_CHECK_EN
  // Misalignment judged on the tick-2 offset while it is still on A1.
  always_comb begin
    misaligned = 1'b0;
    if (cmd_q == CMD_READ16 || cmd_q == CMD_WR16)
      misaligned = A1[0];
    else if (cmd_q == CMD_READ32 || cmd_q == CMD_WR32)
      misaligned = |A1[1:0];
  end
`else
  assign misaligned = 1'b0;
`endif

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cmd_vld) state_d = S_ADDR2;
      S_ADDR2: state_d = misaligned ? S_RESP1 : S_ISSUE;
      S_ISSUE: if (core.req_ready) state_d = core.resp_valid ? S_RESP1 : S_WAIT;
      S_WAIT:  if (core.resp_valid) state_d = S_RESP1;
      S_RESP1: state_d = (cmd_q == CMD_READ32 && !mis_q) ? S_RESP2 : S_IDLE;
      S_RESP2: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Bus drive and request valid per state; the CPU owns C1/D1 in IDLE and ADDR2.
  always_comb begin
    req_vld = 1'b0;
    c1_oe   = 1'b0;
    c1_out  = CMD_NOP;
    d1_oe   = 1'b0;
    d1_out  = 16'h0000;
    case (state_q)
      S_ISSUE: begin
        c1_oe   = 1'b1;
        req_vld = 1'b1;
      end
      S_WAIT: c1_oe = 1'b1;
      S_RESP1: begin
        c1_oe  = 1'b1;
        c1_out = CMD_RESP;
        if (is_read) begin
          d1_oe  = 1'b1;
          d1_out = (cmd_q == CMD_READ8) ? {8'h00, rdata_q[7:0]} : rdata_q[15:0];
        end
      end
      S_RESP2: begin
        c1_oe  = 1'b1;
        c1_out = CMD_RESP;
        d1_oe  = 1'b1;
        d1_out = rdata_q[31:16];
      end
      default: ;
    endcase
  end

  // Payload capture: tick 1 in IDLE, tick 2 in ADDR2, read data on completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_q   <= CMD_NOP;
      tag_q   <= '0;
      set_q   <= '0;
      off_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (cmd_vld) begin
          cmd_q         <= C1;
          tag_q         <= A1[TAG_BITS+SET_BITS-1:SET_BITS];
          set_q         <= A1[SET_BITS-1:0];
          wdata_q[15:0] <= D1;
        end
        S_ADDR2: begin
          off_q          <= A1[OFFSET_BITS-1:0];
          wdata_q[31:16] <= (cmd_q == CMD_WR32) ? D1 : 16'h0000;
          mis_q          <= misaligned;
          // A rejected read answers with zero data.
          if (misaligned) rdata_q <= '0;
        end
        S_ISSUE: if (core.req_ready && core.resp_valid) rdata_q <= core.resp_rdata;
        S_WAIT:  if (core.resp_valid) rdata_q <= core.resp_rdata;
        default: ;
      endcase
    end
  end

  assign core.req_valid  = req_vld;
  assign core.req_cmd    = cmd_q;
  assign core.req_tag    = tag_q;
  assign core.req_set    = set_q;
  assign core.req_offset = off_q;
  assign core.req_wdata  = wdata_q;

  assign C1 = c1_oe ? c1_out : 3'bzzz;
  assign D1 = d1_oe ? d1_out : 16'hzzzz;

endmodule

// File: tb/tb_cache_c1_port.sv
// Directed bench for cache_c1_port: table of transactions plus reset-abort sequence.
// Bus release is probed by briefly driving a known pattern onto the shared net.
// Core side is modelled directly through the interface instance.
module tb_cache_c1_port;

  logic        clk;
  logic        reset;
  logic [14:0] A1;
  logic [2:0]  c1_drv;
  logic        c1_oe;
  logic [15:0] d1_drv;
  logic        d1_oe;
  wire  [2:0]  C1;
  wire  [15:0] D1;

  assign C1 = c1_oe ? c1_drv : 3'bzzz;
  assign D1 = d1_oe ? d1_drv : 16'hzzzz;

  cache_c1_port_if cif ();

  cache_c1_port dut (
    .clk   (clk),
    .reset (reset),
    .C1    (C1),
    .D1    (D1),
    .A1    (A1),
    .core  (cif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  cmd;
    logic [9:0]  tag;
    logic [4:0]  set;
    logic [3:0]  off;
    logic [15:0] d1a;
    logic [15:0] d1b;
    logic [31:0] rdata;
    int          rdy_dly;
    int          wait_n;
    bit          mis;
    logic [31:0] exp_wdata;
    int          exp_n;
    bit          exp_rd;
    logic [15:0] exp_d0;
    logic [15:0] exp_d1;
  } vec_t;

  vec_t vecs[9];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else             n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_d1_released(input string name);
    d1_drv = 16'hA5A5;
    d1_oe  = 1'b1;
    #1;
    chk(name, {16'h0, D1}, 32'h0000A5A5);
    d1_oe  = 1'b0;
  endtask

  // Only safe in IDLE/ADDR2-free moments: the pattern is removed before the next edge.
  task automatic chk_c1_released(input string name);
    c1_drv = 3'b101;
    c1_oe  = 1'b1;
    #1;
    chk(name, {29'h0, C1}, 32'd5);
    c1_oe  = 1'b0;
    c1_drv = 3'b000;
  endtask

  // Entered just after the edge that put the DUT in IDLE; leaves it just after the edge back to IDLE.
  task automatic run_vec(input int idx, input vec_t v);
    string s;
    s = $sformatf("v%0d", idx);
    chk_d1_released({s, "_idle_d1z"});
    c1_drv = v.cmd; c1_oe = 1'b1;
    A1 = {v.tag, v.set};
    d1_drv = v.d1a; d1_oe = 1'b1;
    tick();
    chk({s, "_addr2_vld"}, {31'h0, cif.req_valid}, 32'd0);
    A1 = {11'h5A5, v.off};
    d1_drv = v.d1b;
    c1_drv = 3'd0;
    tick();
    c1_oe = 1'b0; d1_oe = 1'b0;
    A1 = 15'h7FFF;
    if (v.mis) begin
      chk({s, "_mis_vld"}, {31'h0, cif.req_valid}, 32'd0);
    end else begin
      for (int i = 0; i < v.rdy_dly; i++) begin
        chk({s, "_stall_vld"}, {31'h0, cif.req_valid}, 32'd1);
        chk({s, "_stall_wdata"}, cif.req_wdata, v.exp_wdata);
        tick();
      end
      cif.req_ready = 1'b1;
      chk({s, "_vld"},   {31'h0, cif.req_valid}, 32'd1);
      chk({s, "_cmd"},   {29'h0, cif.req_cmd}, {29'h0, v.cmd});
      chk({s, "_tag"},   {22'h0, cif.req_tag}, {22'h0, v.tag});
      chk({s, "_set"},   {27'h0, cif.req_set}, {27'h0, v.set});
      chk({s, "_off"},   {28'h0, cif.req_offset}, {28'h0, v.off});
      chk({s, "_wdata"}, cif.req_wdata, v.exp_wdata);
      if (v.wait_n == 0) begin
        cif.resp_valid = 1'b1;
        cif.resp_rdata = v.rdata;
      end
      tick();
      cif.req_ready  = 1'b0;
      cif.resp_valid = 1'b0;
      cif.resp_rdata = 32'h0BAD0BAD;
      for (int i = 0; i < v.wait_n; i++) begin
        chk({s, "_wait_vld"}, {31'h0, cif.req_valid}, 32'd0);
        if (i == v.wait_n - 1) begin
          cif.resp_valid = 1'b1;
          cif.resp_rdata = v.rdata;
        end
        tick();
        cif.resp_valid = 1'b0;
        cif.resp_rdata = 32'h0BAD0BAD;
      end
    end
    chk({s, "_resp1_c1"}, {29'h0, C1}, 32'd7);
    if (v.exp_rd) chk({s, "_resp1_d1"}, {16'h0, D1}, {16'h0, v.exp_d0});
    else          chk_d1_released({s, "_resp1_d1z"});
    tick();
    if (v.exp_n == 2) begin
      chk({s, "_resp2_c1"}, {29'h0, C1}, 32'd7);
      chk({s, "_resp2_d1"}, {16'h0, D1}, {16'h0, v.exp_d1});
      tick();
    end
    chk({s, "_done_vld"}, {31'h0, cif.req_valid}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation ran past its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    //            cmd  tag     set    off   d1a       d1b       rdata          rdy wt mis exp_wdata     n  rd exp_d0    exp_d1
    vecs[0] = '{3'd1, 10'h155, 5'h0A, 4'h3, 16'h0000, 16'h0000, 32'h000000AB, 0, 0, 0, 32'h00000000, 1, 1, 16'h00AB, 16'h0000};
    vecs[1] = '{3'd3, 10'h3FF, 5'h1F, 4'h4, 16'h1111, 16'h2222, 32'hDEADBEEF, 0, 5, 0, 32'h00001111, 2, 1, 16'hBEEF, 16'hDEAD};
    vecs[2] = '{3'd7, 10'h0F0, 5'h03, 4'h8, 16'h1234, 16'h5678, 32'h00000000, 3, 1, 0, 32'h56781234, 1, 0, 16'h0000, 16'h0000};
    vecs[3] = '{3'd4, 10'h00A, 5'h11, 4'h0, 16'hABCD, 16'hEEEE, 32'h00000000, 0, 0, 0, 32'h0000ABCD, 1, 0, 16'h0000, 16'h0000};
    vecs[4] = '{3'd5, 10'h001, 5'h00, 4'h1, 16'h00CC, 16'h9999, 32'h00000000, 0, 2, 0, 32'h000000CC, 1, 0, 16'h0000, 16'h0000};
    vecs[5] = '{3'd2, 10'h200, 5'h10, 4'h2, 16'h0000, 16'h0000, 32'h12345678, 1, 0, 0, 32'h00000000, 1, 1, 16'h5678, 16'h0000};
    vecs[6] = '{3'd1, 10'h3C3, 5'h05, 4'hF, 16'h0000, 16'h0000, 32'hFFFFFF5C, 2, 3, 0, 32'h00000000, 1, 1, 16'h005C, 16'h0000};
`ifdef C1_ALIGN_CHECK_EN
    vecs[7] = '{3'd3, 10'h111, 5'h0E, 4'h2, 16'h0000, 16'h0000, 32'hCAFEF00D, 0, 1, 1, 32'h00000000, 1, 1, 16'h0000, 16'h0000};
`else
    vecs[7] = '{3'd3, 10'h111, 5'h0E, 4'h2, 16'h0000, 16'h0000, 32'hCAFEF00D, 0, 1, 0, 32'h00000000, 2, 1, 16'hF00D, 16'hCAFE};
`endif
    vecs[8] = '{3'd6, 10'h2B4, 5'h19, 4'h6, 16'hBEEF, 16'h7777, 32'h00000000, 0, 0, 0, 32'h0000BEEF, 1, 0, 16'h0000, 16'h0000};

    reset = 1'b1;
    A1 = '0;
    c1_drv = '0; c1_oe = 1'b0;
    d1_drv = '0; d1_oe = 1'b0;
    cif.req_ready  = 1'b0;
    cif.resp_valid = 1'b0;
    cif.resp_rdata = '0;
    tick();
    tick();
    chk("rst_vld",   {31'h0, cif.req_valid}, 32'd0);
    chk("rst_cmd",   {29'h0, cif.req_cmd}, 32'd0);
    chk("rst_tag",   {22'h0, cif.req_tag}, 32'd0);
    chk("rst_set",   {27'h0, cif.req_set}, 32'd0);
    chk("rst_off",   {28'h0, cif.req_offset}, 32'd0);
    chk("rst_wdata", cif.req_wdata, 32'd0);
    chk_d1_released("rst_d1z");
    reset = 1'b0;
    tick();
    chk_c1_released("rst_c1z");

    // READ32 parked in WAIT, then reset (with a coincident completion that must be dropped).
    c1_drv = 3'd3; c1_oe = 1'b1; A1 = {10'h2AA, 5'h15}; d1_drv = 16'h4444; d1_oe = 1'b1;
    tick();
    A1 = {11'h0, 4'h4}; c1_drv = 3'd0; d1_drv = 16'h0000;
    tick();
    c1_oe = 1'b0; d1_oe = 1'b0;
    chk("rw_issue_vld", {31'h0, cif.req_valid}, 32'd1);
    cif.req_ready = 1'b1;
    tick();
    cif.req_ready = 1'b0;
    chk("rw_wait_vld", {31'h0, cif.req_valid}, 32'd0);
    tick();
    reset = 1'b1;
    cif.resp_valid = 1'b1;
    cif.resp_rdata = 32'h87654321;
    tick();
    reset = 1'b0;
    cif.resp_valid = 1'b0;
    chk("rw_abort_vld", {31'h0, cif.req_valid}, 32'd0);
    chk("rw_abort_cmd", {29'h0, cif.req_cmd}, 32'd0);
    chk_c1_released("rw_abort_c1z");
    chk_d1_released("rw_abort_d1z");
    tick();
    chk_c1_released("rw_noresp_c1z");
    chk_d1_released("rw_noresp_d1z");

    // Back-to-back table: each transaction starts on the first IDLE cycle after the previous one.
    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    chk_c1_released("end_c1z");
    chk_d1_released("end_d1z");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
